// File: rtl/display_rx_module.sv
// Receive side of the serial display link: synchronizes the serial pins, deserializes a 16-bit
// LSB-first BCD frame, validates the digits and converts them to binary with a valid strobe.
module display_rx_module #(
   parameter int unsigned BITS     = 16,
   parameter int unsigned BIN_BITS = 14
) (
   input  logic                internal_clock,
   input  logic                reset_n,
   input  logic                VALUE_SIGNAL,
   input  logic                DATA_CLOCK_SIGNAL,
   input  logic                ENABLE_SIGNAL,
   output logic [BIN_BITS-1:0] VALUE_BIN,
   output logic [BITS-1:0]     VALUE_BCD,
   output logic                VALID,
   output logic                OVERFLOW,
   output logic                FRAME_ERROR
);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StConvert,
      StDone
   } state_e;

   // [0] first sync stage, [1] synchronized level, [2] history for edge detection.
   // Only the level of VALUE is ever sampled, so it has no history flop.
   logic [1:0] val_pipe_q;
   logic [2:0] dclk_pipe_q;
   logic [2:0] en_pipe_q;

   logic val_sync;
   logic dclk_rise;
   logic en_sync;
   logic en_fall;

   state_e              state_q;
   logic [BITS-1:0]     sr_q;
   logic [4:0]          cnt_q;
   logic [BIN_BITS-1:0] acc_q;
   logic [1:0]          digit_idx_q;
   logic                ovf_frame_q;
   logic                bad_frame_q;
   logic                rearm_wait_q;

   logic [3:0]          digit;
   logic [BIN_BITS-1:0] acc_next;
   logic                all_f;
   logic                any_bad;

   always_ff @(posedge internal_clock or negedge reset_n) begin
      if (!reset_n) begin
         val_pipe_q  <= '0;
         dclk_pipe_q <= '0;
         en_pipe_q   <= '0;
      end else begin
         val_pipe_q  <= {val_pipe_q[0], VALUE_SIGNAL};
         dclk_pipe_q <= {dclk_pipe_q[1:0], DATA_CLOCK_SIGNAL};
         en_pipe_q   <= {en_pipe_q[1:0], ENABLE_SIGNAL};
      end
   end

   always_comb begin
      val_sync  = val_pipe_q[1];
      dclk_rise = dclk_pipe_q[1] & ~dclk_pipe_q[2];
      en_sync   = en_pipe_q[1];
      en_fall   = ~en_pipe_q[1] & en_pipe_q[2];
   end

   always_comb begin
      digit    = sr_q[{digit_idx_q, 2'b00} +: 4];
      acc_next = BIN_BITS'(32'(acc_q) * 32'd10 + 32'(digit));
      all_f    = &sr_q;
      any_bad  = 1'b0;
      for (int i = 0; i < int'(BITS / 4); i++) begin
         if (sr_q[4*i +: 4] > 4'd9) begin
            any_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge internal_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         sr_q         <= '0;
         cnt_q        <= '0;
         acc_q        <= '0;
         digit_idx_q  <= '0;
         ovf_frame_q  <= 1'b0;
         bad_frame_q  <= 1'b0;
         rearm_wait_q <= 1'b0;
         VALUE_BIN    <= '0;
         VALUE_BCD    <= '0;
         VALID        <= 1'b0;
         OVERFLOW     <= 1'b0;
         FRAME_ERROR  <= 1'b0;
      end else begin
         VALID       <= 1'b0;
         FRAME_ERROR <= 1'b0;
         case (state_q)
            StIdle: begin
               // After an over-long frame, wait for ENABLE to drop so that the
               // same envelope is not taken as a fresh frame.
               if (!en_sync) begin
                  rearm_wait_q <= 1'b0;
               end else if (!rearm_wait_q) begin
                  sr_q    <= '0;
                  cnt_q   <= '0;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (dclk_rise && en_sync) begin
                  if (cnt_q == 5'(BITS)) begin
                     FRAME_ERROR  <= 1'b1;
                     rearm_wait_q <= 1'b1;
                     state_q      <= StIdle;
                  end else begin
                     sr_q  <= {val_sync, sr_q[BITS-1:1]};
                     cnt_q <= cnt_q + 5'd1;
                  end
               end else if (en_fall) begin
                  if (cnt_q == 5'(BITS)) begin
                     acc_q       <= '0;
                     digit_idx_q <= 2'd3;
                     ovf_frame_q <= all_f;
                     bad_frame_q <= any_bad & ~all_f;
                     state_q     <= StConvert;
                  end else begin
                     FRAME_ERROR <= 1'b1;
                     state_q     <= StIdle;
                  end
               end
            end
            StConvert: begin
               acc_q       <= acc_next;
               digit_idx_q <= digit_idx_q - 2'd1;
               if (digit_idx_q == 2'd0) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (ovf_frame_q) begin
                  VALUE_BCD <= '1;
                  OVERFLOW  <= 1'b1;
                  VALID     <= 1'b1;
               end else if (bad_frame_q) begin
                  FRAME_ERROR <= 1'b1;
               end else begin
                  VALUE_BIN <= acc_q;
                  VALUE_BCD <= sr_q;
                  OVERFLOW  <= 1'b0;
                  VALID     <= 1'b1;
               end
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_rx_module.sv
// Randomized scoreboard bench for display_rx_module: frames are predicted by a digit-level
// model when sent, and a monitor checks every VALID/FRAME_ERROR pulse against the queue.
module tb_display_rx_module;

   logic        internal_clock    = 1'b0;
   logic        reset_n           = 1'b0;
   logic        VALUE_SIGNAL      = 1'b0;
   logic        DATA_CLOCK_SIGNAL = 1'b0;
   logic        ENABLE_SIGNAL     = 1'b0;
   logic [13:0] VALUE_BIN;
   logic [15:0] VALUE_BCD;
   logic        VALID;
   logic        OVERFLOW;
   logic        FRAME_ERROR;

   display_rx_module #(
      .BITS    (16),
      .BIN_BITS(14)
   ) dut (
      .internal_clock   (internal_clock),
      .reset_n          (reset_n),
      .VALUE_SIGNAL     (VALUE_SIGNAL),
      .DATA_CLOCK_SIGNAL(DATA_CLOCK_SIGNAL),
      .ENABLE_SIGNAL    (ENABLE_SIGNAL),
      .VALUE_BIN        (VALUE_BIN),
      .VALUE_BCD        (VALUE_BCD),
      .VALID            (VALID),
      .OVERFLOW         (OVERFLOW),
      .FRAME_ERROR      (FRAME_ERROR)
   );

   always #5 internal_clock = ~internal_clock;

   typedef struct {
      bit          is_err;
      logic [13:0] bin;
      logic [15:0] bcd;
      bit          ovf;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc      = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [13:0] m_bin    = '0;
   logic [15:0] m_bcd    = '0;
   bit          m_ovf    = 1'b0;

   always @(posedge internal_clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input bit is_err, input int unsigned due);
      exp_t e;
      e.is_err = is_err;
      e.bin    = m_bin;
      e.bcd    = m_bcd;
      e.ovf    = m_ovf;
      e.due    = due;
      sb.push_back(e);
   endtask

   // Outcome of a frame whose ENABLE pin dropped at cycle t_fall (pin-to-pulse: 3 cycles for a
   // bad bit count, 3 + 4 digits + 1 done cycle for a decoded frame).
   task automatic predict(input logic [31:0] data, input int nbits, input int unsigned t_fall);
      int unsigned v;
      int unsigned d;
      int unsigned val;
      int unsigned scale;
      bit          bad;
      if (nbits != 16) begin
         push_exp(1'b1, t_fall + 3);
      end else begin
         v = data & 32'hFFFF;
         if (v == 32'hFFFF) begin
            m_bcd = 16'hFFFF;
            m_ovf = 1'b1;
            push_exp(1'b0, t_fall + 8);
         end else begin
            bad   = 1'b0;
            val   = 0;
            scale = 1;
            for (int i = 0; i < 4; i++) begin
               d = (v >> (4 * i)) & 15;
               if (d > 9) bad = 1'b1;
               val   = val + d * scale;
               scale = scale * 10;
            end
            if (bad) begin
               push_exp(1'b1, t_fall + 8);
            end else begin
               m_bin = 14'(val);
               m_bcd = 16'(v);
               m_ovf = 1'b0;
               push_exp(1'b0, t_fall + 8);
            end
         end
      end
   endtask

   task automatic send_bits(input logic [31:0] data, input int n);
      for (int k = 0; k < n; k++) begin
         DATA_CLOCK_SIGNAL = 1'b0;
         VALUE_SIGNAL      = data[k];
         repeat ($urandom_range(4, 6)) @(negedge internal_clock);
         DATA_CLOCK_SIGNAL = 1'b1;
         if (k == 16) push_exp(1'b1, cyc + 3);
         repeat ($urandom_range(4, 6)) @(negedge internal_clock);
      end
      DATA_CLOCK_SIGNAL = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] data, input int nbits);
      @(negedge internal_clock);
      ENABLE_SIGNAL = 1'b1;
      repeat (4) @(negedge internal_clock);
      send_bits(data, nbits);
      repeat (4) @(negedge internal_clock);
      ENABLE_SIGNAL = 1'b0;
      if (nbits <= 16) predict(data, nbits, cyc);
      repeat (12) @(negedge internal_clock);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_value_bin"}, 32'(VALUE_BIN), 32'd0);
      check({tag, "_value_bcd"}, 32'(VALUE_BCD), 32'd0);
      check({tag, "_valid"}, 32'(VALID), 32'd0);
      check({tag, "_overflow"}, 32'(OVERFLOW), 32'd0);
      check({tag, "_frame_error"}, 32'(FRAME_ERROR), 32'd0);
   endtask

   always @(negedge internal_clock) begin
      if (reset_n && (VALID || FRAME_ERROR)) begin
         check("pulse_exclusive", 32'(VALID & FRAME_ERROR), 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: VALID=%0b FRAME_ERROR=%0b at cycle %0d, none expected",
                     VALID, FRAME_ERROR, cyc);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_is_error", 32'(FRAME_ERROR), 32'(mon_e.is_err));
            check("pulse_cycle", cyc, mon_e.due);
            check("value_bin", 32'(VALUE_BIN), 32'(mon_e.bin));
            check("value_bcd", 32'(VALUE_BCD), 32'(mon_e.bcd));
            check("overflow", 32'(OVERFLOW), 32'(mon_e.ovf));
         end
      end
   end

   initial begin
      int          r;
      int          nb;
      logic [31:0] data;

      repeat (3) @(negedge internal_clock);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge internal_clock);

      send_frame(32'h1234, 16);
      send_frame(32'h9999, 16);
      send_frame(32'h0000, 16);
      send_frame(32'h0042, 16);
      send_frame(32'hFFFF, 16);
      send_frame(32'h0005, 16);
      send_frame(32'h03FF, 10);
      send_frame(32'h1ABCD, 17);
      send_frame(32'h12A4, 16);

      // Abort a frame with reset after 8 bits.
      @(negedge internal_clock);
      ENABLE_SIGNAL = 1'b1;
      repeat (4) @(negedge internal_clock);
      send_bits(32'h5678, 8);
      reset_n           = 1'b0;
      ENABLE_SIGNAL     = 1'b0;
      DATA_CLOCK_SIGNAL = 1'b0;
      VALUE_SIGNAL      = 1'b0;
      m_bin = '0;
      m_bcd = '0;
      m_ovf = 1'b0;
      repeat (3) @(negedge internal_clock);
      check_outputs_zero("mid_frame_reset");
      reset_n = 1'b1;
      repeat (10) @(negedge internal_clock);
      send_frame(32'h0321, 16);

      for (int t = 0; t < 40; t++) begin
         r  = $urandom_range(0, 9);
         nb = 16;
         data = '0;
         if (r == 0) begin
            data = 32'hFFFF;
         end else if (r == 1) begin
            data = $urandom & 32'hFFFF;
         end else if (r == 2) begin
            data = $urandom;
            nb   = $urandom_range(0, 15);
         end else if (r == 3) begin
            data = $urandom;
            nb   = 17;
         end else begin
            for (int i = 0; i < 4; i++) data[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         send_frame(data, nb);
      end

      for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge internal_clock);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
